// File: rtl/pe_feeder.sv
// pe_feeder: sequences A/B buffer reads into the my_pe processing element so that
// each follow-on MAC issues in the exact cycle the PE returns its previous partial
// sum, then captures the final dot product behind a valid/ready result port.
//
// Ports:
//   aclk, aresetn           clock, synchronous active-low reset
//   start, busy, err        run control / status (err is sticky until next start)
//   a_addr/a_rdata          A-buffer read port (1-cycle read latency)
//   b_addr/b_rdata          B-buffer read port (1-cycle read latency)
//   pe_ain, pe_din          registered PE operands
//   pe_term, pe_valid       PE control (pe_valid is combinational in WAIT)
//   pe_dvalid, pe_dout      PE result return
//   res_valid/res_data/res_ready  dot-product result handshake
module pe_feeder #(
    parameter int unsigned VEC_LEN = 16,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_rdata,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_rdata,
    output logic [7:0]        pe_ain,
    output logic [7:0]        pe_din,
    output logic              pe_term,
    output logic              pe_valid,
    input  logic              pe_dvalid,
    input  logic [31:0]       pe_dout,
    output logic              res_valid,
    output logic [31:0]       res_data,
    input  logic              res_ready
);

    localparam int unsigned        CNT_W    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0]  LAST_IDX = ADDR_W'(VEC_LEN - 1);
    localparam logic [CNT_W-1:0]   LAST_EXT = CNT_W'(VEC_LEN - 1);
    localparam logic               HAS_PF   = 1'(VEC_LEN > 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LD,
        S_ISSUE,
        S_WAIT,
        S_OUT
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_idx;
    logic               r_op_rdy;
    logic               r_pf1;
    logic               r_pf2;
    logic               r_err;
    logic               r_busy;
    logic               r_term;
    logic               r_res_valid;
    logic [7:0]         r_ain;
    logic [7:0]         r_din;
    logic [31:0]        r_res_data;

    logic               w_start_acc;
    logic               w_issue;
    logic               w_abort;
    logic               w_capture;
    logic               w_pf_set;
    logic [CNT_W-1:0]   w_idx_p2;

    // Address two elements ahead of the one in flight; extra bit avoids wrap.
    assign w_idx_p2 = CNT_W'(r_idx) + CNT_W'(2);

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-cycle decisions
    always_comb begin
        w_next      = r_state;
        w_start_acc = 1'b0;
        w_issue     = 1'b0;
        w_abort     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_next      = S_RD;
                end
            end
            S_RD:    w_next = S_LD;
            S_LD:    w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (pe_dvalid) begin
                    if (r_idx == LAST_IDX) begin
                        w_capture = 1'b1;
                        w_next    = S_OUT;
                    end else if (r_op_rdy) begin
                        w_issue = 1'b1;
                    end else begin
                        w_abort = 1'b1;
                        w_next  = S_IDLE;
                    end
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // A prefetch starts whenever the read address moves forward.
    assign w_pf_set = ((r_state == S_ISSUE) && HAS_PF) ||
                      (w_issue && (w_idx_p2 <= LAST_EXT));

    // Datapath and registered status
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_addr      <= '0;
            r_idx       <= '0;
            r_op_rdy    <= 1'b0;
            r_pf1       <= 1'b0;
            r_pf2       <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_term      <= 1'b0;
            r_res_valid <= 1'b0;
            r_ain       <= '0;
            r_din       <= '0;
            r_res_data  <= '0;
        end else begin
            r_busy      <= (w_next != S_IDLE);
            r_term      <= (w_next == S_ISSUE);
            r_res_valid <= (w_next == S_OUT);
            r_pf1       <= w_pf_set;
            r_pf2       <= r_pf1;

            if (w_start_acc) begin
                r_addr <= '0;
                r_idx  <= '0;
                r_err  <= 1'b0;
            end

            if (r_state == S_LD) begin
                r_ain <= a_rdata;
                r_din <= b_rdata;
            end

            if (r_state == S_ISSUE) begin
                r_op_rdy <= 1'b0;
                if (HAS_PF) begin
                    r_addr <= ADDR_W'(1);
                end
            end

            // Prefetched data lands two cycles after the address moved.
            if (r_pf2 && (r_state == S_WAIT)) begin
                r_ain    <= a_rdata;
                r_din    <= b_rdata;
                r_op_rdy <= 1'b1;
            end

            if (w_issue) begin
                r_idx    <= r_idx + ADDR_W'(1);
                r_op_rdy <= 1'b0;
                if (w_idx_p2 <= LAST_EXT) begin
                    r_addr <= w_idx_p2[ADDR_W-1:0];
                end
            end

            if (w_abort) begin
                r_err <= 1'b1;
            end

            if (w_capture) begin
                r_res_data <= pe_dout;
            end
        end
    end

    // Follow-on MACs issue in the same cycle the partial sum returns.
    assign pe_valid  = r_term | w_issue;
    assign pe_term   = r_term;
    assign pe_ain    = r_ain;
    assign pe_din    = r_din;
    assign a_addr    = r_addr;
    assign b_addr    = r_addr;
    assign busy      = r_busy;
    assign err       = r_err;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: directed bench for pe_feeder with a behavioural PE (integer MAC,
// programmable latency) and two synchronous-read operand buffers. Instance dut
// uses VEC_LEN=4; instance dut1 uses VEC_LEN=1.
module tb_pe_feeder;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic aresetn;
    logic pe_clr;
    int   lat;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    // VEC_LEN=4 instance signals
    logic        start, busy, err, pe_term, pe_valid, pe_dvalid, res_valid, res_ready;
    logic [3:0]  a_addr, b_addr;
    logic [7:0]  a_rdata, b_rdata, pe_ain, pe_din;
    logic [31:0] pe_dout, res_data;
    logic [7:0]  mem_a [16];
    logic [7:0]  mem_b [16];

    // VEC_LEN=1 instance signals
    logic        start1, busy1, err1, pe_term1, pe_valid1, pe_dvalid1, res_valid1, res_ready1;
    logic [3:0]  a_addr1, b_addr1;
    logic [7:0]  a_rdata1, b_rdata1, pe_ain1, pe_din1;
    logic [31:0] pe_dout1, res_data1;
    logic [7:0]  mem_a1 [16];
    logic [7:0]  mem_b1 [16];

    int n_valid = 0, n_term = 0, n_resv = 0, n_valid1 = 0, n_addr1 = 0;

    pe_feeder #(.VEC_LEN(4), .ADDR_W(4)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .busy(busy), .err(err),
        .a_addr(a_addr), .a_rdata(a_rdata), .b_addr(b_addr), .b_rdata(b_rdata),
        .pe_ain(pe_ain), .pe_din(pe_din), .pe_term(pe_term), .pe_valid(pe_valid),
        .pe_dvalid(pe_dvalid), .pe_dout(pe_dout),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
    );

    pe_feeder #(.VEC_LEN(1), .ADDR_W(4)) dut1 (
        .aclk(aclk), .aresetn(aresetn), .start(start1), .busy(busy1), .err(err1),
        .a_addr(a_addr1), .a_rdata(a_rdata1), .b_addr(b_addr1), .b_rdata(b_rdata1),
        .pe_ain(pe_ain1), .pe_din(pe_din1), .pe_term(pe_term1), .pe_valid(pe_valid1),
        .pe_dvalid(pe_dvalid1), .pe_dout(pe_dout1),
        .res_valid(res_valid1), .res_data(res_data1), .res_ready(res_ready1)
    );

    always @(posedge aclk) cyc <= cyc + 1;

    // Synchronous-read buffers
    always @(posedge aclk) begin
        a_rdata  <= mem_a[a_addr];
        b_rdata  <= mem_b[b_addr];
        a_rdata1 <= mem_a1[a_addr1];
        b_rdata1 <= mem_b1[b_addr1];
    end

    // PE model: result = (term ? 0 : last dout) + ain*din, 'lat' cycles later
    logic        pv  [8];
    logic [31:0] pd  [8];
    logic        pv1 [8];
    logic [31:0] pd1 [8];
    always @(posedge aclk) begin
        if (pe_clr) begin
            for (int i = 0; i < 8; i++) begin
                pv[i] <= 1'b0; pd[i] <= '0; pv1[i] <= 1'b0; pd1[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 7; i++) begin
                pv[i] <= pv[i+1]; pd[i] <= pd[i+1]; pv1[i] <= pv1[i+1]; pd1[i] <= pd1[i+1];
            end
            pv[7] <= 1'b0; pd[7] <= '0; pv1[7] <= 1'b0; pd1[7] <= '0;
            if (pe_valid) begin
                pv[3'(lat-1)] <= 1'b1;
                pd[3'(lat-1)] <= (pe_term ? 32'd0 : pe_dout) + 32'(pe_ain) * 32'(pe_din);
            end
            if (pe_valid1) begin
                pv1[3] <= 1'b1;
                pd1[3] <= (pe_term1 ? 32'd0 : pe_dout1) + 32'(pe_ain1) * 32'(pe_din1);
            end
        end
    end
    assign pe_dvalid  = pv[0];
    assign pe_dout    = pd[0];
    assign pe_dvalid1 = pv1[0];
    assign pe_dout1   = pd1[0];

    // Event counters, sampled mid-cycle
    always @(negedge aclk) begin
        if (pe_valid)              n_valid  <= n_valid + 1;
        if (pe_valid && pe_term)   n_term   <= n_term + 1;
        if (res_valid)             n_resv   <= n_resv + 1;
        if (pe_valid1)             n_valid1 <= n_valid1 + 1;
        if ((a_addr1 != 4'd0) || (b_addr1 != 4'd0)) n_addr1 <= n_addr1 + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load_ab(input logic [31:0] a_pk, input logic [31:0] b_pk);
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = a_pk[8*i +: 8];
            mem_b[i] = b_pk[8*i +: 8];
        end
    endtask

    // Raise start for cycle 0; returns at the negedge of cycle 1.
    task automatic pulse_start;
        @(negedge aclk) start = 1'b1;
        @(negedge aclk) start = 1'b0;
    endtask

    // Called in cycle 1; waits for res_valid and checks its cycle and data.
    task automatic wait_res(input string nm, input int exp_cyc, input logic [31:0] exp_data);
        int k = 1;
        while (!res_valid && k < 60) begin
            @(negedge aclk);
            k++;
        end
        chk({nm, " res_valid"}, 32'(res_valid), 32'd1);
        if (res_valid) begin
            chk({nm, " cycle"}, 32'(k), 32'(exp_cyc));
            chk({nm, " data"}, res_data, exp_data);
        end
    endtask

    typedef struct {
        int          c;
        logic        st;
        logic        rdy;
        logic        v;
        logic        t;
        logic        b;
        logic        rv;
        logic [3:0]  ad;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [19];
    int   base;
    int   s_valid, s_term, s_resv, s_valid1;

    initial begin
        // cycle, start, ready | pe_valid, pe_term, busy, res_valid, addr, res_data
        tbl[0]  = '{0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0};
        tbl[1]  = '{1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0};
        tbl[2]  = '{2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0};
        tbl[3]  = '{3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 32'd0};
        tbl[4]  = '{4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 32'd0};
        tbl[5]  = '{6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 32'd0};
        tbl[6]  = '{7,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 32'd0};
        tbl[7]  = '{8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 32'd0};
        tbl[8]  = '{11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 32'd0};
        tbl[9]  = '{12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 32'd0};
        tbl[10] = '{15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 32'd0};
        tbl[11] = '{19, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 32'd0};
        tbl[12] = '{20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'd20};
        tbl[13] = '{22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'd20};
        tbl[14] = '{23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'd20};
        tbl[15] = '{24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'd20};
        tbl[16] = '{25, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'd20};
        tbl[17] = '{26, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 32'd20};
        tbl[18] = '{27, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 32'd20};

        aresetn = 1'b0; pe_clr = 1'b1; lat = 4;
        start = 1'b0; res_ready = 1'b0; start1 = 1'b0; res_ready1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 8'd0; mem_b[i] = 8'd0; mem_a1[i] = 8'd0; mem_b1[i] = 8'd0;
        end
        load_ab({8'd4, 8'd3, 8'd2, 8'd1}, {8'd2, 8'd2, 8'd2, 8'd2});
        mem_a1[0] = 8'd7;
        mem_b1[0] = 8'd9;

        repeat (3) @(negedge aclk);
        chk("rst busy",      32'(busy),      32'd0);
        chk("rst err",       32'(err),       32'd0);
        chk("rst pe_valid",  32'(pe_valid),  32'd0);
        chk("rst pe_term",   32'(pe_term),   32'd0);
        chk("rst res_valid", 32'(res_valid), 32'd0);
        chk("rst res_data",  res_data,       32'd0);
        aresetn = 1'b1;
        pe_clr  = 1'b0;

        // Run 1: table-driven timing, res_ready held low 5 cycles, start in OUT
        @(negedge aclk);
        s_valid = n_valid; s_term = n_term;
        base = cyc;
        for (int i = 0; i < 19; i++) begin
            while (cyc < base + tbl[i].c) @(negedge aclk);
            start     = tbl[i].st;
            res_ready = tbl[i].rdy;
            chk($sformatf("c%0d pe_valid",  tbl[i].c), 32'(pe_valid),  32'(tbl[i].v));
            chk($sformatf("c%0d pe_term",   tbl[i].c), 32'(pe_term),   32'(tbl[i].t));
            chk($sformatf("c%0d busy",      tbl[i].c), 32'(busy),      32'(tbl[i].b));
            chk($sformatf("c%0d res_valid", tbl[i].c), 32'(res_valid), 32'(tbl[i].rv));
            chk($sformatf("c%0d a_addr",    tbl[i].c), 32'(a_addr),    32'(tbl[i].ad));
            chk($sformatf("c%0d b_addr",    tbl[i].c), 32'(b_addr),    32'(tbl[i].ad));
            chk($sformatf("c%0d res_data",  tbl[i].c), res_data,       tbl[i].rd);
        end
        start = 1'b0; res_ready = 1'b0;
        chk("run1 issues", 32'(n_valid - s_valid), 32'd4);
        chk("run1 terms",  32'(n_term - s_term),   32'd1);
        chk("run1 err",    32'(err),               32'd0);

        // Run 2: PE latency 2 -> result arrives before operands, abort with err
        lat = 2;
        s_valid = n_valid; s_resv = n_resv;
        pulse_start();
        repeat (4) @(negedge aclk);
        chk("abort no issue c5", 32'(pe_valid), 32'd0);
        @(negedge aclk);
        chk("abort err c6",  32'(err),  32'd1);
        chk("abort busy c6", 32'(busy), 32'd0);
        repeat (6) @(negedge aclk);
        chk("abort no result", 32'(n_resv - s_resv),   32'd0);
        chk("abort issues",    32'(n_valid - s_valid), 32'd1);
        chk("abort err sticky", 32'(err), 32'd1);
        lat = 4;
        pulse_start();
        chk("restart clears err", 32'(err),  32'd0);
        chk("restart busy",       32'(busy), 32'd1);
        wait_res("restart", 20, 32'd20);
        res_ready = 1'b1;
        @(negedge aclk) res_ready = 1'b0;

        // Run 3: reset during WAIT of element 2, late pe_dvalid ignored
        pulse_start();
        repeat (8) @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        chk("midrst busy",      32'(busy),      32'd0);
        chk("midrst err",       32'(err),       32'd0);
        chk("midrst pe_valid",  32'(pe_valid),  32'd0);
        chk("midrst pe_term",   32'(pe_term),   32'd0);
        chk("midrst res_valid", 32'(res_valid), 32'd0);
        chk("midrst a_addr",    32'(a_addr),    32'd0);
        chk("midrst b_addr",    32'(b_addr),    32'd0);
        chk("midrst pe_ain",    32'(pe_ain),    32'd0);
        chk("midrst pe_din",    32'(pe_din),    32'd0);
        chk("midrst res_data",  res_data,       32'd0);
        @(negedge aclk);
        chk("late dvalid no issue", 32'(pe_valid), 32'd0);
        @(negedge aclk);
        chk("late dvalid busy",      32'(busy),      32'd0);
        chk("late dvalid res_valid", 32'(res_valid), 32'd0);
        load_ab({8'd1, 8'd1, 8'd1, 8'd1}, {8'd3, 8'd3, 8'd3, 8'd3});
        pulse_start();
        wait_res("post-reset", 20, 32'd12);
        res_ready = 1'b1;
        @(negedge aclk) res_ready = 1'b0;

        // Run 4: back-to-back with res_ready high, operands reloaded in between
        res_ready = 1'b1;
        load_ab({8'd4, 8'd3, 8'd2, 8'd1}, {8'd2, 8'd2, 8'd2, 8'd2});
        pulse_start();
        wait_res("b2b first", 20, 32'd20);
        load_ab({8'd8, 8'd7, 8'd6, 8'd5}, {8'd1, 8'd1, 8'd1, 8'd1});
        pulse_start();
        wait_res("b2b second", 20, 32'd26);
        @(negedge aclk);
        res_ready = 1'b0;
        chk("b2b idle", 32'(busy), 32'd0);

        // VEC_LEN=1: single term issue, no prefetch, addresses stay 0
        s_valid1 = n_valid1;
        @(negedge aclk) start1 = 1'b1;
        @(negedge aclk) start1 = 1'b0;
        repeat (2) @(negedge aclk);
        chk("v1 pe_valid c3", 32'(pe_valid1), 32'd1);
        chk("v1 pe_term c3",  32'(pe_term1),  32'd1);
        begin
            int k = 3;
            while (!res_valid1 && k < 40) begin
                @(negedge aclk);
                k++;
            end
            chk("v1 res_valid", 32'(res_valid1), 32'd1);
            chk("v1 res cycle", 32'(k),          32'd8);
            chk("v1 res_data",  res_data1,       32'd63);
        end
        res_ready1 = 1'b1;
        @(negedge aclk) res_ready1 = 1'b0;
        @(negedge aclk);
        chk("v1 issues",     32'(n_valid1 - s_valid1), 32'd1);
        chk("v1 addr moved", 32'(n_addr1),             32'd0);
        chk("v1 idle",       32'(busy1),               32'd0);
        chk("v1 err",        32'(err1),                32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
